// File: rtl/gpu2d_video_pkg.sv
// Shared definitions for the 2D GPU video path.
//   H_PIXELS / V_PIXELS / V_TOTAL : default display timing (visible pixels,
//                                   visible lines, total lines per frame)
//   VRAM_ADDR_W / VRAM_DATA_W     : scanline VRAM write-port widths
//   sched_state_t                 : scanline render scheduler states
package gpu2d_video_pkg;

   localparam int unsigned H_PIXELS    = 800;
   localparam int unsigned V_PIXELS    = 600;
   localparam int unsigned V_TOTAL     = 618;

   localparam int unsigned VRAM_ADDR_W = 10;
   localparam int unsigned VRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      DONE
   } sched_state_t;

endpackage

// File: rtl/scanline_render_scheduler.sv
// Scanline render scheduler.
// On every line start, it picks the next visible line and asks the renderer
// to draw it. The pixel stream is written into whichever even/odd line
// buffer is not being scanned out. Missed deadlines are counted as underruns.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   line_start, line_index   line-begin pulse from the timing generator
//   render_req/_line/_ack    job handshake with the renderer
//   render_abort             one-cycle pulse when the current job is cancelled
//   pix_valid/_data/_ready   pixel stream from the renderer
//   vram_{even,odd}_wr_*     registered write ports of the two line buffers
//   line_done                one-cycle pulse aligned with the last write of a line
//   busy                     a job is requested or being filled
//   underrun_cnt             saturating count of missed deadlines
module scanline_render_scheduler #(
   parameter int unsigned H_PIXELS        = gpu2d_video_pkg::H_PIXELS,
   parameter int unsigned V_PIXELS        = gpu2d_video_pkg::V_PIXELS,
   parameter int unsigned V_TOTAL         = gpu2d_video_pkg::V_TOTAL,
   parameter int unsigned V_COUNTER_WIDTH = $clog2(V_TOTAL)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   line_start,
   input  logic [V_COUNTER_WIDTH-1:0]             line_index,
   output logic                                   render_req,
   output logic [V_COUNTER_WIDTH-1:0]             render_line,
   input  logic                                   render_ack,
   output logic                                   render_abort,
   input  logic                                   pix_valid,
   input  logic [gpu2d_video_pkg::VRAM_DATA_W-1:0] pix_data,
   output logic                                   pix_ready,
   output logic [gpu2d_video_pkg::VRAM_ADDR_W-1:0] vram_even_wr_addr,
   output logic [gpu2d_video_pkg::VRAM_DATA_W-1:0] vram_even_wr_data,
   output logic                                   vram_even_we,
   output logic [gpu2d_video_pkg::VRAM_ADDR_W-1:0] vram_odd_wr_addr,
   output logic [gpu2d_video_pkg::VRAM_DATA_W-1:0] vram_odd_wr_data,
   output logic                                   vram_odd_we,
   output logic                                   line_done,
   output logic                                   busy,
   output logic [15:0]                            underrun_cnt
);
   import gpu2d_video_pkg::*;

   sched_state_t                 state;
   sched_state_t                 state_nxt;
   logic [VRAM_ADDR_W-1:0]       pix_cnt;
   logic [V_COUNTER_WIDTH-1:0]   render_line_q;
   logic                         tgt_valid;
   logic [V_COUNTER_WIDTH-1:0]   tgt_line;
   logic                         accept;
   logic                         last_pix;
   logic                         underrun;
   logic                         cur_odd;

   // Target line for the line now beginning: the last line of the frame
   // wraps to line 0; lines whose successor is in blanking have no job.
   always_comb begin
      tgt_valid = 1'b0;
      tgt_line  = '0;
      if (32'(line_index) == V_TOTAL - 1) begin
         tgt_valid = 1'b1;
      end else if (32'(line_index) + 1 < V_PIXELS) begin
         tgt_valid = 1'b1;
         tgt_line  = line_index + V_COUNTER_WIDTH'(1);
      end
   end

   assign cur_odd  = render_line_q[0];
   assign accept   = (state == FILL) && pix_valid;
   assign last_pix = accept && (pix_cnt == VRAM_ADDR_W'(H_PIXELS - 1));
   // Completing the last pixel in the same cycle as line_start is not a miss.
   assign underrun = line_start && ((state == REQ) || ((state == FILL) && !last_pix));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      render_req = 1'b0;
      pix_ready  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (line_start) begin
               state_nxt = tgt_valid ? REQ : IDLE;
            end
         end
         REQ: begin
            render_req = 1'b1;
            busy       = 1'b1;
            if (line_start) begin
               state_nxt = tgt_valid ? REQ : IDLE;
            end else if (render_ack) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            pix_ready = 1'b1;
            busy      = 1'b1;
            if (line_start) begin
               state_nxt = tgt_valid ? REQ : IDLE;
            end else if (last_pix) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign render_line = render_line_q;

   // Datapath. The write demux uses the buffer of the job in flight before
   // render_line_q is updated, so a last pixel coinciding with a new job
   // still lands in the old buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt           <= '0;
         render_line_q     <= '0;
         render_abort      <= 1'b0;
         line_done         <= 1'b0;
         underrun_cnt      <= '0;
         vram_even_we      <= 1'b0;
         vram_even_wr_addr <= '0;
         vram_even_wr_data <= '0;
         vram_odd_we       <= 1'b0;
         vram_odd_wr_addr  <= '0;
         vram_odd_wr_data  <= '0;
      end else begin
         render_abort <= underrun;
         line_done    <= last_pix;

         if (underrun && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
         end

         if (line_start && tgt_valid) begin
            render_line_q <= tgt_line;
         end

         if (line_start || last_pix) begin
            pix_cnt <= '0;
         end else if (accept) begin
            pix_cnt <= pix_cnt + VRAM_ADDR_W'(1);
         end

         vram_even_we <= accept && !cur_odd;
         vram_odd_we  <= accept && cur_odd;
         if (accept && !cur_odd) begin
            vram_even_wr_addr <= pix_cnt;
            vram_even_wr_data <= pix_data;
         end
         if (accept && cur_odd) begin
            vram_odd_wr_addr <= pix_cnt;
            vram_odd_wr_data <= pix_data;
         end
      end
   end

endmodule

// File: doc/scanline_render_scheduler.md
# scanline_render_scheduler

Sequences the dual scanline VRAM (even/odd line buffers) that the video scan-out reads. At each line start it schedules rendering of the next visible line into the buffer not being displayed. It handshakes with the pixel renderer, steers its pixel stream into that buffer's write port, and counts underruns when rendering misses the line deadline. It sits between the video timing generator and the 2D renderer.

## Interface
Parameters:
- H_PIXELS, 800: pixels per visible line; must be ≤ 1024.
- V_PIXELS, 600: visible lines.
- V_TOTAL, 618: total lines per frame; must be even.
- V_COUNTER_WIDTH, $clog2(V_TOTAL): width of line indices.

Ports:
- clk  in  1  system/pixel clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- line_start  in  1  one-cycle pulse on the first cycle of each scanline.
- line_index  in  V_COUNTER_WIDTH  index of the line beginning; valid with line_start.
- render_req  out  1  job request to renderer.
- render_line  out  V_COUNTER_WIDTH  target line of current job; stable while render_req is high.
- render_ack  in  1  renderer accepts the job.
- render_abort  out  1  one-cycle pulse; the current job is cancelled.
- pix_valid  in  1  renderer pixel valid.
- pix_data  in  8  pixel value.
- pix_ready  out  1  block accepts a pixel.
- vram_even_wr_addr / vram_odd_wr_addr  out  10  write address.
- vram_even_wr_data / vram_odd_wr_data  out  8  write data.
- vram_even_we / vram_odd_we  out  1  write enable.
- line_done  out  1  one-cycle pulse when a line is fully written.
- busy  out  1  high in REQ or FILL.
- underrun_cnt  out  16  saturating count of missed deadlines.

## Operation
- Target on line_start with index L:
  - L == V_TOTAL-1 → target T = 0.
  - L+1 < V_PIXELS → T = L+1.
  - Otherwise there is no job; the FSM enters or stays in IDLE.
- Buffer select is T[0]: 1 → odd buffer, 0 → even buffer. The non-selected buffer's we stays 0 at all times.
- FSM states: IDLE, REQ, FILL, DONE.
  - IDLE/DONE + line_start with a valid target → REQ.
  - REQ: render_req=1 until render_ack is sampled high → FILL.
  - FILL: pix_ready=1. Each pix_valid&&pix_ready writes pix_data at address = pixel counter (0..H_PIXELS-1), then the counter increments. Acceptance of pixel H_PIXELS-1 → DONE with line_done pulse.
  - DONE: idle until the next line_start.
- Underrun: a line_start while in REQ or FILL triggers all of the following:
  - render_abort pulses.
  - underrun_cnt increments, saturating at 16'hFFFF.
  - The pixel counter clears.
  - The FSM re-enters REQ for the new target (or IDLE if there is none).
- Simultaneous events:
  - Last-pixel acceptance + line_start in the same cycle → completion wins: line_done pulses, no underrun, and the new job starts.
  - render_ack + line_start in the same cycle in REQ → underrun.
- Pixel writes are addressed only by the counter; the renderer never supplies addresses.
- Reset mid-operation: all state clears immediately. No abort pulse is generated. The renderer is reset by the same rst_n.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, the counter and underrun_cnt are 0.
- With line_start at cycle t:
  - render_req and render_line are valid at t+1.
  - On an underrun, render_abort is high at t+1, in the same cycle as the new render_req.
- render_req falls in the cycle after render_ack is sampled. pix_ready rises in that same cycle.
- Write latency is 1 cycle. A pixel accepted at cycle c appears as we/addr/data at c+1. we is high for exactly one cycle per pixel.
- line_done rises at c+1 for the last pixel's c, aligned with the final write. busy falls at the same time.
- Minimum line service time is 2 + H_PIXELS cycles with continuous pix_valid and immediate ack.
- pix_ready=0 in all states except FILL. Pixels offered outside FILL are not written.

## Structure
- Shared package gpu2d_video_pkg holds:
  - The default timing constants H_PIXELS, V_PIXELS, V_TOTAL.
  - The VRAM address and data widths (10/8).
  - The state enum typedef sched_state_t {IDLE, REQ, FILL, DONE}.
- Single module, no sub-module. Even/odd write-port steering is a registered demux inside.

## Test plan
Use H_PIXELS=8, V_PIXELS=4, V_TOTAL=6 unless noted.
- Reset check: assert rst_n=0 mid-FILL → all outputs 0 the same cycle (asynchronous). After release, no activity until line_start.
- Normal line: line_start L=0, ack at the next cycle, 8 continuous pixels 0x10..0x17 → odd buffer writes addr 0..7 with data 0x10..0x17. vram_even_we stays 0. One line_done pulse. underrun_cnt=0.
- Frame wrap and blanking:
  - line_start L=5 → render_line=0, even buffer selected.
  - L=3 and L=4 → no render_req.
- Underrun: start job for L=1; supply 5 pixels; line_start L=2 → render_abort pulse, underrun_cnt=1, new render_req with render_line=3, writes restart at addr 0 of the odd buffer.
- Simultaneous events:
  - Last pixel accepted in the same cycle as line_start → line_done=1, underrun_cnt unchanged.
  - ack coincident with line_start → underrun_cnt increments.
- Backpressure and saturation:
  - pix_valid toggling 50% → addresses remain contiguous 0..7 with no duplicate writes.
  - Preload underrun_cnt=16'hFFFF via forced underruns → stays at 16'hFFFF.
